mips_debug_unit: RTL and testbench

Parametrised debug and loader controller for the pipelined MIPS core. It sits between a byte-stream link (UART RX/TX FIFOs) and `TOP_MIPS`, and drives the debug ports that are tied off by hand in simulation today. The block loads a program into instruction memory, runs the core either continuously or one clock at a time, and streams the collected state back to the host: PC, register file, data memory and the pipeline latches.

---
 rtl/mips_debug_unit_if.sv | 49 ++++
 rtl/mips_debug_unit.sv | 236 +++++++++++++++++++++++
 tb/tb_mips_debug_unit.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_debug_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : mips_debug_unit_if
//  Purpose  : Byte-link and core debug-port bundle for the MIPS debug unit.
//             The master view belongs to the debug unit. The slave view
//             belongs to the link and core side.
//  Revision : 1.0 - initial release
// ============================================================================
interface mips_debug_unit_if #(
    parameter int DATA_W  = 32,
    parameter int N_LATCH = 4
);
    // Byte link
    logic [7:0]                rx_data;
    logic                      rx_valid;
    logic [7:0]                tx_data;
    logic                      tx_valid;
    logic                      tx_ready;

    // Core control and loader
    logic                      mips_enable;
    logic                      debug_flag;
    logic [DATA_W-1:0]         in_addr_mem_inst;
    logic [DATA_W-1:0]         in_ins_to_mem;
    logic                      wea_ram_inst;
    logic [DATA_W-1:0]         in_addr_debug;

    // Core state readback
    logic [DATA_W-1:0]         out_pc;
    logic [DATA_W-1:0]         out_reg1_recolector;
    logic [DATA_W-1:0]         out_mem_wire;
    logic [N_LATCH*DATA_W-1:0] latches;
    logic                      halt_flag;

    modport master (
        input  rx_data, rx_valid, tx_ready,
        input  out_pc, out_reg1_recolector, out_mem_wire, latches, halt_flag,
        output tx_data, tx_valid, mips_enable, debug_flag,
        output in_addr_mem_inst, in_ins_to_mem, wea_ram_inst, in_addr_debug
    );

    modport slave (
        output rx_data, rx_valid, tx_ready,
        output out_pc, out_reg1_recolector, out_mem_wire, latches, halt_flag,
        input  tx_data, tx_valid, mips_enable, debug_flag,
        input  in_addr_mem_inst, in_ins_to_mem, wea_ram_inst, in_addr_debug
    );
endinterface
`default_nettype wire

// File: rtl/mips_debug_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mips_debug_unit
//  Purpose  : Program loader and debug controller for the pipelined MIPS
//             core. It loads instruction memory from a byte stream, runs the
//             core continuously or for a single step, and then dumps the PC,
//             registers, data memory and pipeline latches back to the host.
//  Revision : 1.0 - initial release
// ============================================================================
module mips_debug_unit #(
    parameter int DATA_W  = 32,
    parameter int N_REGS  = 32,
    parameter int N_MEM   = 16,
    parameter int N_LATCH = 4,
    parameter int CNT_W   = 16
) (
    input  wire logic         clk,
    input  wire logic         reset,
    mips_debug_unit_if.master bus
);
    localparam int WORD_BYTES  = DATA_W / 8;
    localparam int LEN_BYTES   = CNT_W / 8;
    localparam int REG_BASE    = 1;
    localparam int MEM_BASE    = REG_BASE + N_REGS;
    localparam int LAT_BASE    = MEM_BASE + N_MEM;
    localparam int TOTAL_WORDS = LAT_BASE + N_LATCH;
    localparam int IDX_W       = $clog2(TOTAL_WORDS + 1);

    localparam logic [7:0]       CMD_LOAD  = 8'h01;
    localparam logic [7:0]       CMD_RUN   = 8'h02;
    localparam logic [7:0]       CMD_STEP  = 8'h03;
    localparam logic [7:0]       ACK_BYTE  = 8'hAA;
    localparam logic [7:0]       WORD_LAST = 8'(WORD_BYTES - 1);
    localparam logic [7:0]       LEN_LAST  = 8'(LEN_BYTES - 1);
    localparam logic [IDX_W-1:0] DUMP_LAST = IDX_W'(TOTAL_WORDS - 1);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        LEN       = 4'd1,
        WORD      = 4'd2,
        WRITE     = 4'd3,
        ACK       = 4'd4,
        RUN       = 4'd5,
        STEP      = 4'd6,
        DUMP_ADDR = 4'd7,
        DUMP_CAP  = 4'd8,
        DUMP_TX   = 4'd9
    } state_t;

    state_t            state;
    logic [7:0]        byte_cnt;
    logic [CNT_W-1:0]  prog_len;
    logic [CNT_W-1:0]  word_idx;
    logic [DATA_W-1:0] shreg;
    logic [IDX_W-1:0]  dump_idx;

    logic [CNT_W-1:0]  len_next;
    logic [DATA_W-1:0] word_next;
    logic [DATA_W-1:0] shreg_shifted;
    logic [DATA_W-1:0] dump_word;
    logic [DATA_W-1:0] dump_addr;
    int                dump_pos;

    // Incoming bytes are shifted in MSB first. Outgoing bytes leave from the top of shreg.
    assign len_next      = (prog_len << 8) | CNT_W'(bus.rx_data);
    assign shreg_shifted = shreg << 8;
    assign word_next     = shreg_shifted | DATA_W'(bus.rx_data);
    assign dump_pos      = {{(32-IDX_W){1'b0}}, dump_idx};

    // Map the dump word position to a debug read address and its data source.
    always_comb begin
        dump_word = bus.out_pc;
        dump_addr = '0;
        if (dump_pos >= REG_BASE && dump_pos < MEM_BASE) begin
            dump_addr = DATA_W'(dump_pos - REG_BASE);
            dump_word = bus.out_reg1_recolector;
        end else if (dump_pos >= MEM_BASE && dump_pos < LAT_BASE) begin
            dump_addr = DATA_W'(dump_pos - MEM_BASE);
            dump_word = bus.out_mem_wire;
        end
        for (int k = 0; k < N_LATCH; k++) begin
            if (dump_pos == LAT_BASE + k) begin
                dump_word = bus.latches[k*DATA_W +: DATA_W];
            end
        end
    end

    // Control FSM. All outputs are registered here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state                <= IDLE;
            byte_cnt             <= '0;
            prog_len             <= '0;
            word_idx             <= '0;
            shreg                <= '0;
            dump_idx             <= '0;
            bus.tx_data          <= '0;
            bus.tx_valid         <= 1'b0;
            bus.mips_enable      <= 1'b0;
            bus.debug_flag       <= 1'b0;
            bus.in_addr_mem_inst <= '0;
            bus.in_ins_to_mem    <= '0;
            bus.wea_ram_inst     <= 1'b0;
            bus.in_addr_debug    <= '0;
        end else begin
            bus.wea_ram_inst <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.rx_valid) begin
                        case (bus.rx_data)
                            CMD_LOAD: begin
                                state          <= LEN;
                                byte_cnt       <= '0;
                                prog_len       <= '0;
                                word_idx       <= '0;
                                bus.debug_flag <= 1'b1;
                            end
                            CMD_RUN: begin
                                state           <= RUN;
                                bus.mips_enable <= 1'b1;
                            end
                            CMD_STEP: begin
                                state           <= STEP;
                                bus.mips_enable <= 1'b1;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end

                LEN: begin
                    if (bus.rx_valid) begin
                        prog_len <= len_next;
                        if (byte_cnt == LEN_LAST) begin
                            byte_cnt <= '0;
                            if (len_next == '0) begin
                                state        <= ACK;
                                bus.tx_valid <= 1'b1;
                                bus.tx_data  <= ACK_BYTE;
                            end else begin
                                state <= WORD;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 8'd1;
                        end
                    end
                end

                // In WRITE a new byte is accepted as the first byte of the next word.
                WORD, WRITE: begin
                    if (state == WRITE && word_idx == prog_len) begin
                        state        <= ACK;
                        bus.tx_valid <= 1'b1;
                        bus.tx_data  <= ACK_BYTE;
                    end else if (bus.rx_valid) begin
                        shreg <= word_next;
                        if (byte_cnt == WORD_LAST) begin
                            byte_cnt             <= '0;
                            bus.wea_ram_inst     <= 1'b1;
                            bus.in_addr_mem_inst <= DATA_W'(word_idx) << 2;
                            bus.in_ins_to_mem    <= word_next;
                            word_idx             <= word_idx + CNT_W'(1);
                            state                <= WRITE;
                        end else begin
                            byte_cnt <= byte_cnt + 8'd1;
                            state    <= WORD;
                        end
                    end else begin
                        state <= WORD;
                    end
                end

                ACK: begin
                    if (bus.tx_ready) begin
                        bus.tx_valid   <= 1'b0;
                        bus.debug_flag <= 1'b0;
                        state          <= IDLE;
                    end
                end

                RUN: begin
                    if (bus.halt_flag) begin
                        bus.mips_enable <= 1'b0;
                        bus.debug_flag  <= 1'b1;
                        dump_idx        <= '0;
                        state           <= DUMP_ADDR;
                    end
                end

                STEP: begin
                    bus.mips_enable <= 1'b0;
                    bus.debug_flag  <= 1'b1;
                    dump_idx        <= '0;
                    state           <= DUMP_ADDR;
                end

                DUMP_ADDR: begin
                    bus.in_addr_debug <= dump_addr;
                    state             <= DUMP_CAP;
                end

                // The address has been stable for a full cycle, so read data is valid.
                DUMP_CAP: begin
                    shreg        <= dump_word;
                    bus.tx_data  <= dump_word[DATA_W-1 -: 8];
                    bus.tx_valid <= 1'b1;
                    byte_cnt     <= '0;
                    state        <= DUMP_TX;
                end

                DUMP_TX: begin
                    if (bus.tx_ready) begin
                        if (byte_cnt == WORD_LAST) begin
                            bus.tx_valid <= 1'b0;
                            byte_cnt     <= '0;
                            if (dump_idx == DUMP_LAST) begin
                                bus.debug_flag <= 1'b0;
                                state          <= IDLE;
                            end else begin
                                dump_idx <= dump_idx + IDX_W'(1);
                                state    <= DUMP_ADDR;
                            end
                        end else begin
                            shreg       <= shreg_shifted;
                            bus.tx_data <= shreg_shifted[DATA_W-1 -: 8];
                            byte_cnt    <= byte_cnt + 8'd1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mips_debug_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_debug_unit
//  Purpose  : Self-checking bench for mips_debug_unit. It uses a behavioural
//             core and memory model and a byte-level expectation of the dump.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mips_debug_unit;
    localparam int DW = 32;
    localparam int NR = 32;
    localparam int NM = 16;
    localparam int NL = 4;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_debug_unit_if #(.DATA_W(DW), .N_LATCH(NL)) bus ();

    mips_debug_unit #(
        .DATA_W (DW),
        .N_REGS (NR),
        .N_MEM  (NM),
        .N_LATCH(NL),
        .CNT_W  (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Behavioural core state with combinational debug reads.
    logic [DW-1:0]    pc_m;
    logic [DW-1:0]    regs_m [NR];
    logic [DW-1:0]    mem_m  [NM];
    logic [DW-1:0]    lat_m  [NL];
    logic [NL*DW-1:0] lat_bus;

    always_comb begin
        lat_bus = '0;
        for (int k = 0; k < NL; k++) lat_bus[k*DW +: DW] = lat_m[k];
    end
    assign bus.out_pc              = pc_m;
    assign bus.out_reg1_recolector = regs_m[bus.in_addr_debug[4:0]];
    assign bus.out_mem_wire        = mem_m[bus.in_addr_debug[3:0]];
    assign bus.latches             = lat_bus;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] wr_q[$];
    int          wr_cyc_q[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  exp_q[$];
    int          en_cnt;
    int          last_en_cyc;
    int          last_byte_cyc;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data  = 8'h00;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Monitor: log writes, tx transfers and enable cycles, and check the tx hold rule.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.wea_ram_inst) begin
                wr_q.push_back({bus.in_addr_mem_inst, bus.in_ins_to_mem});
                wr_cyc_q.push_back(cyc);
            end
            if (bus.tx_valid && bus.tx_ready) tx_q.push_back(bus.tx_data);
            if (bus.mips_enable) begin
                en_cnt++;
                last_en_cyc = cyc;
            end
            if (prev_stall) begin
                chk("tx_hold_valid", 64'(bus.tx_valid), 64'd1);
                chk("tx_hold_data", 64'(bus.tx_data), 64'(prev_data));
            end
            prev_stall = bus.tx_valid && !bus.tx_ready;
            prev_data  = bus.tx_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    function automatic logic [63:0] wr_at(input int i);
        if (i < wr_q.size()) return wr_q[i];
        return 'x;
    endfunction

    function automatic logic [7:0] tx_at(input int i);
        if (i < tx_q.size()) return tx_q[i];
        return 'x;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        wr_q.delete();
        wr_cyc_q.delete();
        tx_q.delete();
        en_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data   = b;
        bus.rx_valid  = 1'b1;
        last_byte_cyc = cyc;
        @(posedge clk);
        #1;
        bus.rx_valid  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int b = 3; b >= 0; b--) begin
            tick($urandom_range(0, max_gap));
            send_byte(w[b*8 +: 8]);
        end
    endtask

    task automatic wait_ack(input string tag);
        int k = 0;
        while (tx_q.size() < 1 && k < 60) begin
            tick(1);
            k++;
        end
        tick(2);
        chk({tag, "_ack_count"}, 64'(tx_q.size()), 64'd1);
        chk({tag, "_ack_byte"}, 64'(tx_at(0)), 64'hAA);
    endtask

    task automatic randomize_core();
        pc_m = $urandom;
        for (int i = 0; i < NR; i++) regs_m[i] = $urandom;
        for (int i = 0; i < NM; i++) mem_m[i]  = $urandom;
        for (int i = 0; i < NL; i++) lat_m[i]  = $urandom;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
    endtask

    // Collect a full dump under a random tx_ready. Hold tx_ready low 5 cycles mid-word.
    task automatic run_dump(input string tag, input bit inject_run);
        int  k        = 0;
        bit  held     = 1'b0;
        bit  injected = 1'b0;
        int  diffs    = 0;
        while (tx_q.size() < 212 && k < 3000) begin
            if (!held && tx_q.size() >= 2) begin
                bus.tx_ready = 1'b0;
                tick(5);
                held = 1'b1;
                chk({tag, "_dbg_in_dump"}, 64'(bus.debug_flag), 64'd1);
            end else if (inject_run && !injected && tx_q.size() >= 50) begin
                bus.tx_ready = 1'b1;
                send_byte(8'h02);
                injected = 1'b1;
            end else begin
                bus.tx_ready = ($urandom_range(0, 3) != 0);
                tick(1);
            end
            k++;
        end
        bus.tx_ready = 1'b1;
        tick(12);
        exp_q.delete();
        push_word(pc_m);
        for (int i = 0; i < NR; i++) push_word(regs_m[i]);
        for (int i = 0; i < NM; i++) push_word(mem_m[i]);
        for (int i = 0; i < NL; i++) push_word(lat_m[i]);
        for (int i = 0; i < exp_q.size(); i++)
            if (tx_at(i) !== exp_q[i]) diffs++;
        chk({tag, "_dump_len"}, 64'(tx_q.size()), 64'(exp_q.size()));
        chk({tag, "_dump_diffs"}, 64'(diffs), 64'd0);
        chk({tag, "_dump_pc_msb"}, 64'(tx_at(0)), 64'(pc_m[31:24]));
        chk({tag, "_dbg_after"}, 64'(bus.debug_flag), 64'd0);
    endtask

    initial begin
        logic [31:0] wlist[$];
        logic [31:0] w0;
        int          n;
        int          c0;
        int          w0_last;

        bus.rx_data   = 8'h00;
        bus.rx_valid  = 1'b0;
        bus.tx_ready  = 1'b1;
        bus.halt_flag = 1'b0;
        reset         = 1'b0;
        en_cnt        = 0;
        randomize_core();

        // Reset held low for two edges
        tick(2);
        chk("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
        chk("rst_tx_data", 64'(bus.tx_data), 64'd0);
        chk("rst_enable", 64'(bus.mips_enable), 64'd0);
        chk("rst_debug_flag", 64'(bus.debug_flag), 64'd0);
        chk("rst_addr_inst", 64'(bus.in_addr_mem_inst), 64'd0);
        chk("rst_ins", 64'(bus.in_ins_to_mem), 64'd0);
        chk("rst_wea", 64'(bus.wea_ram_inst), 64'd0);
        chk("rst_addr_debug", 64'(bus.in_addr_debug), 64'd0);
        reset = 1'b1;
        tick(1);

        // Unknown command byte is dropped
        clear_logs();
        send_byte(8'h55);
        tick(5);
        chk("junk_tx", 64'(tx_q.size()), 64'd0);
        chk("junk_wr", 64'(wr_q.size()), 64'd0);
        chk("junk_en", 64'(en_cnt), 64'd0);
        chk("junk_dbg", 64'(bus.debug_flag), 64'd0);

        // Directed two-word load, bytes back to back
        clear_logs();
        send_byte(8'h01);
        chk("load_dbg", 64'(bus.debug_flag), 64'd1);
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(32'h20010005, 0);
        w0_last = last_byte_cyc;
        send_word(32'hFC000000, 0);
        wait_ack("load2");
        chk("load2_wr_count", 64'(wr_q.size()), 64'd2);
        chk("load2_wr0", wr_at(0), {32'd0, 32'h20010005});
        chk("load2_wr1", wr_at(1), {32'd4, 32'hFC000000});
        chk("load2_wr0_timing", 64'(wr_cyc_q.size() > 0 ? wr_cyc_q[0] : -1), 64'(w0_last + 1));
        chk("load2_dbg_idle", 64'(bus.debug_flag), 64'd0);

        // Empty program: acknowledge without any write
        clear_logs();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_ack("load0");
        chk("load0_wr_count", 64'(wr_q.size()), 64'd0);

        // Random loads with random gaps between bytes
        for (int it = 0; it < 3; it++) begin
            clear_logs();
            wlist.delete();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) wlist.push_back($urandom);
            send_byte(8'h01);
            send_byte(8'(n >> 8));
            send_byte(8'(n));
            for (int i = 0; i < n; i++) send_word(wlist[i], 2);
            wait_ack("rload");
            chk("rload_wr_count", 64'(wr_q.size()), 64'(n));
            for (int i = 0; i < n; i++)
                chk("rload_wr", wr_at(i), {32'(4 * i), wlist[i]});
        end

        // Single step followed by a dump
        randomize_core();
        clear_logs();
        send_byte(8'h03);
        run_dump("step", 1'b0);
        chk("step_en_cycles", 64'(en_cnt), 64'd1);

        // Run until halt is raised at cycle 10, with a RUN byte injected mid-dump
        randomize_core();
        clear_logs();
        send_byte(8'h02);
        c0 = last_byte_cyc;
        tick(9);
        bus.halt_flag = 1'b1;
        tick(1);
        chk("run_en_cycles", 64'(en_cnt), 64'd10);
        chk("run_en_last", 64'(last_en_cyc), 64'(c0 + 10));
        run_dump("run", 1'b1);
        chk("run_en_after_dump", 64'(en_cnt), 64'd10);

        // Run with halt already high on entry
        randomize_core();
        clear_logs();
        send_byte(8'h02);
        run_dump("runhalt", 1'b0);
        chk("runhalt_en_le1", 64'(en_cnt <= 1), 64'd1);
        bus.halt_flag = 1'b0;

        // Reset in the middle of the second word, then a fresh load
        clear_logs();
        w0 = $urandom;
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(w0, 0);
        send_byte(8'h12);
        send_byte(8'h34);
        reset = 1'b0;
        tick(1);
        chk("midrst_wea", 64'(bus.wea_ram_inst), 64'd0);
        chk("midrst_dbg", 64'(bus.debug_flag), 64'd0);
        reset = 1'b1;
        tick(3);
        chk("midrst_wr_count", 64'(wr_q.size()), 64'd1);
        chk("midrst_tx", 64'(tx_q.size()), 64'd0);
        w0 = $urandom;
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(w0, 1);
        wait_ack("reload");
        chk("reload_wr_count", 64'(wr_q.size()), 64'd2);
        chk("reload_wr", wr_at(1), {32'd0, w0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
